// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse generator core: FSM encoding, enable-register
// bit positions and the packed time-of-day layout used by the start-time comparator.
package pulse_gen_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;
    localparam int unsigned EN_BIT        = 0;
    localparam int unsigned RESYNC_BIT    = 1;
    localparam int unsigned TIME_W        = 56;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StRun   = 2'd2,
        StErr   = 2'd3
    } pg_state_e;

    // Most significant field first, so a plain unsigned compare is lexicographic.
    function automatic logic [TIME_W-1:0] pack_time(
        input logic [15:0] year,
        input logic [7:0]  month,
        input logic [7:0]  day,
        input logic [7:0]  hour,
        input logic [7:0]  minutes,
        input logic [7:0]  seconds
    );
        return {year, month, day, hour, minutes, seconds};
    endfunction

endpackage

// File: rtl/pg_time_compare.sv
// Combinational "current time has reached start time" check on packed date/time words.
module pg_time_compare
    import pulse_gen_pkg::*;
(
    input  logic [TIME_W-1:0] cur_i,
    input  logic [TIME_W-1:0] start_i,
    output logic              ge_o
);

    assign ge_o = (cur_i >= start_i);

endmodule

// File: rtl/pulse_generator_core.sv
// Periodic pulse generator: arms on enable, starts on the first PPS at or after the
// programmed start time, then produces width/period pulses counted in microsecond ticks.
module pulse_generator_core
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick_us,
    input  logic             i_pps,
    input  logic [15:0]      i_cur_year,
    input  logic [7:0]       i_cur_month,
    input  logic [7:0]       i_cur_day,
    input  logic [7:0]       i_cur_hour,
    input  logic [7:0]       i_cur_minutes,
    input  logic [7:0]       i_cur_seconds,
    input  logic [7:0]       i_pulse_enable,
    input  logic [7:0]       i_usr_year_h,
    input  logic [7:0]       i_usr_year_l,
    input  logic [7:0]       i_usr_month,
    input  logic [7:0]       i_usr_day,
    input  logic [7:0]       i_usr_hour,
    input  logic [7:0]       i_usr_minutes,
    input  logic [7:0]       i_usr_seconds,
    input  logic [7:0]       i_width_high_3,
    input  logic [7:0]       i_width_high_2,
    input  logic [7:0]       i_width_high_1,
    input  logic [7:0]       i_width_high_0,
    input  logic [7:0]       i_width_period_3,
    input  logic [7:0]       i_width_period_2,
    input  logic [7:0]       i_width_period_1,
    input  logic [7:0]       i_width_period_0,
    output logic             o_pulse,
    output logic [1:0]       o_state,
    output logic             o_cfg_err,
    output logic [CNT_W-1:0] o_pulse_count
);

    pg_state_e          state_q;
    logic               pulse_q;
    logic               cfg_err_q;
    logic [CNT_W-1:0]   pulse_cnt_q;
    logic [CNT_W-1:0]   us_cnt_q;
    logic [CNT_W-1:0]   width_q;
    logic [CNT_W-1:0]   period_q;
    logic [TIME_W-1:0]  start_q;

    logic [CNT_W-1:0]   width_in;
    logic [CNT_W-1:0]   period_in;
    logic [TIME_W-1:0]  start_in;
    logic [TIME_W-1:0]  cur_time;
    logic               cfg_bad;
    logic               start_reached;
    logic               us_wrap;
    logic [CNT_W-1:0]   us_step;
    logic               resync_hit;

    logic unused_enable_bits;
    assign unused_enable_bits = ^i_pulse_enable[7:2];

    assign width_in  = CNT_W'({i_width_high_3, i_width_high_2, i_width_high_1, i_width_high_0});
    assign period_in = CNT_W'({i_width_period_3, i_width_period_2,
                               i_width_period_1, i_width_period_0});
    assign start_in  = pack_time({i_usr_year_h, i_usr_year_l}, i_usr_month, i_usr_day,
                                 i_usr_hour, i_usr_minutes, i_usr_seconds);
    assign cur_time  = pack_time(i_cur_year, i_cur_month, i_cur_day,
                                 i_cur_hour, i_cur_minutes, i_cur_seconds);

    assign cfg_bad = (width_in == '0) || (period_in == '0) || (width_in >= period_in);

    pg_time_compare u_time_compare (
        .cur_i   (cur_time),
        .start_i (start_q),
        .ge_o    (start_reached)
    );

    assign us_wrap    = (us_cnt_q == period_q - CNT_W'(1));
    assign us_step    = us_wrap ? '0 : us_cnt_q + CNT_W'(1);
    assign resync_hit = i_pulse_enable[RESYNC_BIT] && i_pps;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            pulse_q     <= 1'b0;
            cfg_err_q   <= 1'b0;
            pulse_cnt_q <= '0;
            us_cnt_q    <= '0;
            width_q     <= '0;
            period_q    <= '0;
            start_q     <= '0;
        end else if (!i_pulse_enable[EN_BIT]) begin
            // Pulse count is left alone so software can still read the last run's total.
            state_q   <= StIdle;
            pulse_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            us_cnt_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    width_q  <= width_in;
                    period_q <= period_in;
                    start_q  <= start_in;
                    if (cfg_bad) begin
                        state_q   <= StErr;
                        cfg_err_q <= 1'b1;
                        pulse_q   <= 1'b0;
                    end else begin
                        state_q     <= StArmed;
                        pulse_cnt_q <= '0;
                    end
                end
                StArmed: begin
                    if (i_pps && start_reached) begin
                        state_q  <= StRun;
                        us_cnt_q <= '0;
                        pulse_q  <= 1'b1;
                    end
                end
                StRun: begin
                    // PPS realignment takes priority over a coincident tick.
                    if (resync_hit) begin
                        us_cnt_q <= '0;
                        pulse_q  <= 1'b1;
                        if (us_cnt_q != '0) begin
                            pulse_cnt_q <= pulse_cnt_q + CNT_W'(1);
                        end
                    end else if (i_tick_us) begin
                        us_cnt_q <= us_step;
                        pulse_q  <= (us_step < width_q);
                        if (us_wrap) begin
                            pulse_cnt_q <= pulse_cnt_q + CNT_W'(1);
                        end
                    end
                end
                StErr: begin
                    pulse_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_pulse       = pulse_q;
    assign o_state       = state_q;
    assign o_cfg_err     = cfg_err_q;
    assign o_pulse_count = pulse_cnt_q;

endmodule

// File: doc/pulse_generator_core.md
Name: pulse_generator_core

Overview:
- Downstream consumer of the pulse-generator register bank.
- Takes the user-programmed start date/time, high width and period, plus the live time-of-day and timing strobes from the clock master.
- Emits a periodic pulse train that starts on the first PPS at or after the programmed start time.
- Owns start-time arming, microsecond counting, config validation and a pulse counter for status readback.

Parameters:
- CNT_W, 32, width of microsecond counter, width/period config and pulse counter.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_tick_us  in  1  one-cycle strobe per microsecond
- i_pps  in  1  one-cycle strobe at each second boundary
- i_cur_year  in  16  binary year of the second starting at i_pps
- i_cur_month, i_cur_day, i_cur_hour, i_cur_minutes, i_cur_seconds  in  8 each  binary current time fields
- i_pulse_enable  in  8  bit0 = enable, bit1 = resync on every PPS; bits 7:2 ignored
- i_usr_year_h, i_usr_year_l  in  8 each  start year {h,l}
- i_usr_month, i_usr_day, i_usr_hour, i_usr_minutes, i_usr_seconds  in  8 each  start time
- i_width_high_3..0  in  8 each  high width in us, {3,2,1,0} with 3 as MSB
- i_width_period_3..0  in  8 each  period in us, same byte order
- o_pulse  out  1  registered pulse output
- o_state  out  2  FSM state
- o_cfg_err  out  1  config rejected
- o_pulse_count  out  CNT_W  completed periods since entering RUN

Behaviour:
- Reset: FSM in IDLE. o_pulse=0, o_state=IDLE, o_cfg_err=0, o_pulse_count=0, us_cnt=0, all shadow registers 0.
- Clock and reset: reset i_rst, synchronous, active-high; clock i_clk.
- State encoding: IDLE=0, ARMED=1, RUN=2, ERR=3.
- Enable low in any state: next cycle go to IDLE with o_pulse=0, o_cfg_err=0 and us_cnt=0. o_pulse_count holds its value.
- IDLE, enable bit0 high:
  - Latch width, period and start time into shadow registers.
  - width==0, period==0 or width>=period: go to ERR and set o_cfg_err=1.
  - Otherwise go to ARMED and clear o_pulse_count.
- Register-bank writes after the latch are ignored until enable is cycled low then high.
- ARMED:
  - Start condition: on i_pps, compare the current time against the shadow start time, lexicographically as year, month, day, hour, minute, second, unsigned.
  - If current >= start: go to RUN, set us_cnt=0 and o_pulse=1 in the same edge.
  - Latency: o_pulse rises on the cycle after i_pps.
  - A start time in the past therefore starts at the next PPS.
  - i_tick_us is ignored in ARMED.
- RUN, on each i_tick_us:
  - If us_cnt==period-1: next us_cnt=0 and o_pulse_count increments; otherwise next us_cnt=us_cnt+1.
  - o_pulse <= (next us_cnt < width).
  - The pulse is high for exactly width ticks per period.
- RUN, resync (bit1=1) with i_pps:
  - us_cnt<=0, o_pulse<=1.
  - o_pulse_count increments only if us_cnt!=0, i.e. a partial period counts as completed.
  - i_tick_us in the same cycle is ignored (PPS wins).
- RUN with bit1=0: i_pps has no effect.
- o_pulse_count wraps from 2^CNT_W-1 to 0 silently.
- ERR: o_pulse=0. Held until enable bit0 goes low.
- Reset mid-RUN: all outputs take reset values on the next edge.

Decomposition:
- Package pulse_gen_pkg holds:
  - state encoding constants;
  - enable bit indices EN_BIT=0 and RESYNC_BIT=1;
  - CNT_W default.
- Sub-module pg_time_compare: combinational 56-bit packed-time >= comparator, instantiated once.

Test Plan:
- width=3, period=10, start=2024-01-01 00:00:05, enable=0x01; PPS at cur 00:00:04 then at 00:00:05 -> stays ARMED after the first PPS; o_pulse=1 the cycle after the second PPS, high for 3 ticks and low for 7; o_pulse_count=1 after the 10th tick.
- Start time 2020-06-01 00:00:00 with cur 2024-01-01 -> RUN on the first PPS (past start).
- width=10, period=10 -> ERR with o_cfg_err=1 and o_pulse=0; enable to 0 -> IDLE with o_cfg_err=0. Repeat with width=0 and with period=0 -> ERR each time.
- enable=0x03, period=1000, PPS asserted at us_cnt=400 together with a tick -> us_cnt=0, o_pulse=1, o_pulse_count +1, tick ignored.
- Change i_width_high_0 from 3 to 5 while in RUN -> pulse stays 3 ticks wide; after enable 0->1 the new width of 5 applies.
- Assert i_rst while o_pulse=1 in RUN -> next cycle o_pulse=0, o_state=IDLE, o_pulse_count=0.
